// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the opcode constants used to build instruction words, the reset
// (NOP) instruction word and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [15:0] INSTRUCTION_NOP = 16'h0000;
  localparam logic [15:0] INSTRUCTION_AND = 16'h0001;
  localparam logic [15:0] INSTRUCTION_SUB = 16'h0002;

  // Word presented to the decoder out of reset: a NOP with empty fields.
  localparam logic [31:0] NOP_WORD = {INSTRUCTION_NOP, 16'h0000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the decoder.
// Keeps the program counter, reads instruction memory with a req/ack
// handshake, captures each word into the instruction register and hands it
// to the decoder with valid/ready. A one-cycle jump redirect squashes any
// in-flight or unconsumed fetch.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   en                       run enable
//   mem_req/mem_addr         read request and address (mem_addr == pc)
//   mem_ack/mem_rdata        one-cycle acknowledge with read data
//   instr/instr_valid/_ready instruction register and decoder handshake
//   instr_pc                 address the held instruction came from
//   jump_en/jump_addr        redirect request and target
//   pc                       next fetch address
//
// state | meaning
// IDLE  | no request outstanding; waits for en, accepts jumps directly
// REQ   | mem_req high at pc until mem_ack; jumps are latched, not applied
// HOLD  | instr_valid high until the decoder accepts it or a jump squashes it
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  jump_pending_q, jump_pending_d;
  logic [ADDR_WIDTH-1:0] jump_tgt_q, jump_tgt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= PC_RESET;
      instr_q        <= NOP_WORD;
      instr_pc_q     <= '0;
      jump_pending_q <= 1'b0;
      jump_tgt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      jump_pending_q <= jump_pending_d;
      jump_tgt_q     <= jump_tgt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    jump_pending_d = jump_pending_q;
    jump_tgt_d     = jump_tgt_q;

    case (state_q)
      IDLE: begin
        if (jump_en) pc_d = jump_addr;
        if (en) state_d = REQ;
      end
      REQ: begin
        // pc must not move while the request is up, so jumps are parked.
        if (jump_en) begin
          jump_pending_d = 1'b1;
          jump_tgt_d     = jump_addr;
        end
        if (mem_ack) begin
          if (jump_en || jump_pending_q) begin
            pc_d           = jump_en ? jump_addr : jump_tgt_q;
            jump_pending_d = 1'b0;
            state_d        = IDLE;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        // Handshake and squash both free the register; a jump always
        // redirects pc, whether or not the transfer completed.
        if (instr_ready || jump_en) begin
          if (jump_en) pc_d = jump_addr;
          state_d = en ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_pc;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] w;

  instr_fetch #(.ADDR_WIDTH(8), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else pass_cnt++;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++;
    if (pc !== 8'h00) $display("FAIL reset_pc got %h want 00", pc); else pass_cnt++;
    total_cnt++;
    if (instr !== {INSTRUCTION_NOP, 16'h0000}) $display("FAIL reset_instr got %h want %h", instr, {INSTRUCTION_NOP, 16'h0000}); else pass_cnt++;
    total_cnt++;
    if (instr_pc !== 8'h00) $display("FAIL reset_instr_pc got %h want 00", instr_pc); else pass_cnt++;
    tick();
    tick();
  endtask

  task automatic test_first_fetch();
    rst = 1'b0; en = 1'b1;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL first_req got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr); else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1) $display("FAIL first_wait got valid=%b req=%b want valid=0 req=1", instr_valid, mem_req); else pass_cnt++;
    w = {INSTRUCTION_AND, 8'h0F, 8'hF0};
    mem_ack = 1'b1; mem_rdata = w;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr !== w) $display("FAIL first_capture got valid=%b instr=%h want valid=1 instr=%h", instr_valid, instr, w); else pass_cnt++;
    total_cnt++;
    if (instr_pc !== 8'h00 || pc !== 8'h01 || mem_req !== 1'b0) $display("FAIL first_pc got instr_pc=%h pc=%h req=%b want 00 01 0", instr_pc, pc, mem_req); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // A stray ack outside REQ must not disturb the held instruction.
      mem_ack = (i == 2); mem_rdata = 32'h1234_5678;
      tick();
      total_cnt++;
      if (instr !== w || instr_valid !== 1'b1 || instr_pc !== 8'h00 || mem_req !== 1'b0)
        $display("FAIL hold_stable cycle %0d got instr=%h valid=%b ipc=%h req=%b want %h 1 00 0", i, instr, instr_valid, instr_pc, mem_req, w);
      else pass_cnt++;
    end
    mem_ack = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h01) $display("FAIL release got valid=%b req=%b addr=%h want 0 1 01", instr_valid, mem_req, mem_addr); else pass_cnt++;
    w = {INSTRUCTION_AND, 8'h11, 8'h22};
    mem_ack = 1'b1; mem_rdata = w;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (instr !== w || instr_pc !== 8'h01 || pc !== 8'h02) $display("FAIL second_fetch got instr=%h ipc=%h pc=%h want %h 01 02", instr, instr_pc, pc, w); else pass_cnt++;
    en = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL idle_after_en_low got valid=%b req=%b want 0 0", instr_valid, mem_req); else pass_cnt++;
  endtask

  task automatic test_wrap();
    jump_en = 1'b1; jump_addr = 8'hFF;
    tick();
    jump_en = 1'b0;
    total_cnt++;
    if (pc !== 8'hFF || mem_req !== 1'b0) $display("FAIL idle_jump got pc=%h req=%b want FF 0", pc, mem_req); else pass_cnt++;
    en = 1'b1;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'hFF) $display("FAIL wrap_req got req=%b addr=%h want 1 FF", mem_req, mem_addr); else pass_cnt++;
    w = {INSTRUCTION_NOP, 8'hAA, 8'h55};
    mem_ack = 1'b1; mem_rdata = w;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (instr_pc !== 8'hFF || pc !== 8'h00) $display("FAIL wrap_pc got ipc=%h pc=%h want FF 00", instr_pc, pc); else pass_cnt++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL wrap_next got req=%b addr=%h want 1 00", mem_req, mem_addr); else pass_cnt++;
  endtask

  task automatic test_jump_in_req();
    // Finish the fetch at 00, go idle, then redirect to 03.
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0; en = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 8'h03;
    tick();
    jump_en = 1'b0; en = 1'b1;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h03) $display("FAIL req_at_3 got req=%b addr=%h want 1 03", mem_req, mem_addr); else pass_cnt++;
    jump_en = 1'b1; jump_addr = 8'h40;
    tick();
    jump_en = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h03) $display("FAIL addr_stable_on_jump got req=%b addr=%h want 1 03", mem_req, mem_addr); else pass_cnt++;
    tick();
    mem_ack = 1'b1; mem_rdata = {INSTRUCTION_SUB, 8'h01, 8'h02};
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc !== 8'h40) $display("FAIL squash_in_req got valid=%b req=%b pc=%h want 0 0 40", instr_valid, mem_req, pc); else pass_cnt++;
    total_cnt++;
    if (instr === {INSTRUCTION_SUB, 8'h01, 8'h02}) $display("FAIL squashed_word_captured got instr=%h want not %h", instr, {INSTRUCTION_SUB, 8'h01, 8'h02}); else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h40 || instr_valid !== 1'b0) $display("FAIL refetch_40 got req=%b addr=%h valid=%b want 1 40 0", mem_req, mem_addr, instr_valid); else pass_cnt++;
  endtask

  task automatic test_jump_in_hold();
    w = {INSTRUCTION_AND, 8'h40, 8'h40};
    mem_ack = 1'b1; mem_rdata = w;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || pc !== 8'h41) $display("FAIL fetch_40 got valid=%b ipc=%h pc=%h want 1 40 41", instr_valid, instr_pc, pc); else pass_cnt++;
    jump_en = 1'b1; jump_addr = 8'h10; instr_ready = 1'b0;
    tick();
    jump_en = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h10) $display("FAIL hold_squash got valid=%b req=%b addr=%h want 0 1 10", instr_valid, mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0010;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (instr !== 32'hCAFE_0010 || instr_pc !== 8'h10 || pc !== 8'h11) $display("FAIL fetch_10 got instr=%h ipc=%h pc=%h want CAFE0010 10 11", instr, instr_pc, pc); else pass_cnt++;
    jump_en = 1'b1; jump_addr = 8'h10; instr_ready = 1'b1;
    tick();
    jump_en = 1'b0; instr_ready = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h10) $display("FAIL hold_jump_ready got valid=%b req=%b addr=%h want 0 1 10", instr_valid, mem_req, mem_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00) $display("FAIL async_reset got req=%b valid=%b pc=%h want 0 0 00", mem_req, instr_valid, pc); else pass_cnt++;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL restart got req=%b addr=%h want 1 00", mem_req, mem_addr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_wrap();
    test_jump_in_req();
    test_jump_in_hold();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
